// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit arbiter.
package udp_pkg;

    localparam int UDP_HDR_FIELD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } udp_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    int c;

    // Scan from the farthest offset down so the nearest hit is the one kept.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        c       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            c = int'(ptr_i) + i;
            if (c >= N) c = c - N;
            if (req_i[IW'(c)]) begin
                idx_o   = IW'(c);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arb.sv
// Round-robin arbiter sharing one udp_tx engine among NUM_PORTS header+payload sources.
// Define UDP_TX_ARB_STATS_EN to enable the per-port 16-bit packet counters.
module udp_tx_arb
    import udp_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int AXI_DATA_WIDTH = 8,
    localparam int GW            = $clog2(NUM_PORTS)
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic [NUM_PORTS-1:0]                  s_udp_hdr_tvalid,
    output logic [NUM_PORTS-1:0]                  s_udp_hdr_trdy,
    input  logic [NUM_PORTS*16-1:0]               s_udp_src_port,
    input  logic [NUM_PORTS*16-1:0]               s_udp_dst_port,
    input  logic [NUM_PORTS*16-1:0]               s_udp_hdr_checksum,
    input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
    output logic [NUM_PORTS-1:0]                  s_axis_trdy,
    output logic                                  m_udp_hdr_tvalid,
    input  logic                                  m_udp_hdr_trdy,
    output logic [15:0]                           m_udp_src_port,
    output logic [15:0]                           m_udp_dst_port,
    output logic [15:0]                           m_udp_hdr_checksum,
    output logic [AXI_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_trdy,
    output logic [GW-1:0]                         o_grant,
    output logic                                  o_busy,
    output logic [NUM_PORTS*16-1:0]               o_pkt_count
);

    localparam int FW = UDP_HDR_FIELD_W;

    udp_arb_state_t state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]  pick_idx;
    logic           pick_found;
    logic [GW-1:0]  grant_nxt;
    logic           hdr_hs;
    logic           last_hs;

    rr_picker #(.N(NUM_PORTS), .IW(GW)) u_picker (
        .req_i   (s_udp_hdr_tvalid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign hdr_hs    = (state_q == HDR) && s_udp_hdr_tvalid[grant_q] && m_udp_hdr_trdy;
    assign last_hs   = (state_q == PAYLOAD) && s_axis_tvalid[grant_q] && m_axis_trdy
                       && s_axis_tlast[grant_q];
    assign grant_nxt = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        m_udp_hdr_tvalid = 1'b0;
        m_axis_tvalid    = 1'b0;
        s_udp_hdr_trdy   = '0;
        s_axis_trdy      = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = HDR;
                end
            end
            HDR: begin
                m_udp_hdr_tvalid        = s_udp_hdr_tvalid[grant_q];
                s_udp_hdr_trdy[grant_q] = m_udp_hdr_trdy;
                if (hdr_hs) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                m_axis_tvalid        = s_axis_tvalid[grant_q];
                s_axis_trdy[grant_q] = m_axis_trdy;
                if (last_hs) begin
                    rr_ptr_d = grant_nxt;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data paths stay muxed by grant even when the matching valid is low.
    assign m_udp_src_port     = s_udp_src_port[int'(grant_q)*FW +: FW];
    assign m_udp_dst_port     = s_udp_dst_port[int'(grant_q)*FW +: FW];
    assign m_udp_hdr_checksum = s_udp_hdr_checksum[int'(grant_q)*FW +: FW];
    assign m_axis_tdata       = s_axis_tdata[int'(grant_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign m_axis_tlast       = s_axis_tlast[grant_q];
    assign o_grant            = grant_q;
    assign o_busy             = (state_q != IDLE);

`ifdef UDP_TX_ARB_STATS_EN
    logic [NUM_PORTS-1:0][FW-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (last_hs) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
        end
    end

    assign o_pkt_count = cnt_q;
`else
    assign o_pkt_count = '0;
`endif

endmodule

// File: tb/tb_udp_tx_arb.sv
// Randomized scoreboard bench for udp_tx_arb: packet-level round-robin model vs DUT.
module tb_udp_tx_arb;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int GW = 2;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic [NP-1:0]        s_udp_hdr_tvalid;
    logic [NP-1:0]        s_udp_hdr_trdy;
    logic [NP*16-1:0]     s_udp_src_port;
    logic [NP*16-1:0]     s_udp_dst_port;
    logic [NP*16-1:0]     s_udp_hdr_checksum;
    logic [NP*DW-1:0]     s_axis_tdata;
    logic [NP-1:0]        s_axis_tvalid;
    logic [NP-1:0]        s_axis_tlast;
    logic [NP-1:0]        s_axis_trdy;
    logic                 m_udp_hdr_tvalid;
    logic                 m_udp_hdr_trdy;
    logic [15:0]          m_udp_src_port;
    logic [15:0]          m_udp_dst_port;
    logic [15:0]          m_udp_hdr_checksum;
    logic [DW-1:0]        m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_trdy;
    logic [GW-1:0]        o_grant;
    logic                 o_busy;
    logic [NP*16-1:0]     o_pkt_count;

    udp_tx_arb #(.NUM_PORTS(NP), .AXI_DATA_WIDTH(DW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .s_udp_hdr_tvalid(s_udp_hdr_tvalid), .s_udp_hdr_trdy(s_udp_hdr_trdy),
        .s_udp_src_port(s_udp_src_port), .s_udp_dst_port(s_udp_dst_port),
        .s_udp_hdr_checksum(s_udp_hdr_checksum),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_trdy(s_axis_trdy),
        .m_udp_hdr_tvalid(m_udp_hdr_tvalid), .m_udp_hdr_trdy(m_udp_hdr_trdy),
        .m_udp_src_port(m_udp_src_port), .m_udp_dst_port(m_udp_dst_port),
        .m_udp_hdr_checksum(m_udp_hdr_checksum),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_trdy(m_axis_trdy),
        .o_grant(o_grant), .o_busy(o_busy), .o_pkt_count(o_pkt_count)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Packet store: each source port holds a queue of packet ids.
    logic [15:0] pk_src [512];
    logic [15:0] pk_dst [512];
    logic [15:0] pk_cs  [512];
    logic [7:0]  pk_seed[512];
    int          pk_len [512];
    int          npk = 0;
    int          pq[NP][$];
    bit          hdr_done[NP];
    int          beat_i[NP];

    typedef struct { int port; logic [15:0] src; logic [15:0] dst; logic [15:0] cs; } hexp_t;
    typedef struct { int port; logic [7:0] data; logic last; } bexp_t;
    hexp_t exp_h[$];
    bexp_t exp_b[$];

    int m_ptr = 0;
    int m_cnt[NP];
    bit hold = 0;
    int stop_after = 0;
    int beats_seen = 0;
    int cur_port = 0;
    bit gap_chk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int id, input int b);
        return 8'(int'(pk_seed[id]) + b * 29 + (b >> 2));
    endfunction

    task automatic new_pkt(input int p, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] c, input int len);
        pk_src[npk] = s; pk_dst[npk] = d; pk_cs[npk] = c;
        pk_len[npk] = len; pk_seed[npk] = 8'($urandom);
        pq[p].push_back(npk);
        npk++;
    endtask

    task automatic rand_pkt(input int p, input int len);
        new_pkt(p, 16'($urandom), 16'($urandom), 16'($urandom), len);
    endtask

    // Reference: every loaded port requests continuously; the next winner is the
    // first port with work at or after the pointer, and the pointer moves past it.
    task automatic schedule();
        int cnt[NP];
        int k[NP];
        int remaining;
        int p;
        int id;
        remaining = 0;
        for (int i = 0; i < NP; i++) begin
            cnt[i] = pq[i].size(); k[i] = 0; remaining += cnt[i];
        end
        while (remaining > 0) begin
            for (int i = 0; i < NP; i++) begin
                p = (m_ptr + i) % NP;
                if (cnt[p] > 0) begin
                    id = pq[p][k[p]];
                    exp_h.push_back('{p, pk_src[id], pk_dst[id], pk_cs[id]});
                    for (int b = 0; b < pk_len[id]; b++)
                        exp_b.push_back('{p, pbyte(id, b), (b == pk_len[id] - 1)});
                    k[p]++; cnt[p]--; remaining--; m_cnt[p]++;
                    m_ptr = (p + 1) % NP;
                    break;
                end
            end
        end
    endtask

    // Source and sink driver.
    initial begin
        logic [NP-1:0] hh, hd;
        int id;
        s_udp_hdr_tvalid = '0; s_udp_src_port = '0; s_udp_dst_port = '0;
        s_udp_hdr_checksum = '0; s_axis_tdata = '0; s_axis_tvalid = '0;
        s_axis_tlast = '0; m_udp_hdr_trdy = 1'b0; m_axis_trdy = 1'b0;
        forever begin
            @(negedge i_clk);
            hh = s_udp_hdr_tvalid & s_udp_hdr_trdy;
            hd = s_axis_tvalid & s_axis_trdy;
            @(posedge i_clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (pq[p].size() > 0) begin
                    id = pq[p][0];
                    if (hh[p]) hdr_done[p] = 1'b1;
                    if (hd[p]) begin
                        beat_i[p]++;
                        if (beat_i[p] == pk_len[id]) begin
                            void'(pq[p].pop_front());
                            hdr_done[p] = 1'b0;
                            beat_i[p] = 0;
                        end
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (pq[p].size() > 0) begin
                    id = pq[p][0];
                    s_udp_hdr_tvalid[p]        = !hdr_done[p];
                    s_udp_src_port[16*p +: 16] = pk_src[id];
                    s_udp_dst_port[16*p +: 16] = pk_dst[id];
                    s_udp_hdr_checksum[16*p +: 16] = pk_cs[id];
                    s_axis_tvalid[p]           = hdr_done[p] && ($urandom_range(0, 3) != 0);
                    s_axis_tdata[DW*p +: DW]   = pbyte(id, beat_i[p]);
                    s_axis_tlast[p]            = (beat_i[p] == pk_len[id] - 1);
                end else begin
                    s_udp_hdr_tvalid[p] = 1'b0;
                    s_axis_tvalid[p]    = 1'b0;
                end
            end
            m_udp_hdr_trdy = ($urandom_range(0, 3) != 0);
            m_axis_trdy    = hold ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        hexp_t h;
        bexp_t b;
        forever begin
            @(negedge i_clk);
            if (i_reset) continue;
            if (gap_chk) begin
                chk("gap_hdr_tvalid", m_udp_hdr_tvalid, 0);
                chk("gap_busy", o_busy, 0);
                gap_chk = 0;
            end
            if (s_udp_hdr_trdy != 0)
                chk("hdr_trdy_owner", s_udp_hdr_trdy,
                    (exp_h.size() > 0) ? (64'd1 << exp_h[0].port) : 64'd0);
            if (s_axis_trdy != 0)
                chk("axis_trdy_owner", s_axis_trdy, 64'd1 << cur_port);
            if (m_udp_hdr_tvalid && m_udp_hdr_trdy) begin
                if (exp_h.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL hdr_unexpected: got header from grant %0d, expected none", o_grant);
                end else begin
                    h = exp_h.pop_front();
                    chk("hdr_grant", o_grant, h.port);
                    chk("hdr_src", m_udp_src_port, h.src);
                    chk("hdr_dst", m_udp_dst_port, h.dst);
                    chk("hdr_csum", m_udp_hdr_checksum, h.cs);
                    cur_port = h.port;
                end
            end
            if (m_axis_tvalid && m_axis_trdy) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: got beat %0h, expected none", m_axis_tdata);
                end else begin
                    b = exp_b.pop_front();
                    chk("beat_grant", o_grant, b.port);
                    chk("beat_data", m_axis_tdata, b.data);
                    chk("beat_last", m_axis_tlast, b.last);
                    beats_seen++;
                    if (b.last) gap_chk = 1;
                    if (stop_after != 0 && beats_seen == stop_after) begin
                        hold = 1;
                        m_axis_trdy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        for (int p = 0; p < NP; p++) begin
            pq[p].delete(); hdr_done[p] = 0; beat_i[p] = 0; m_cnt[p] = 0;
        end
        exp_h.delete(); exp_b.delete();
        m_ptr = 0; hold = 0; stop_after = 0; beats_seen = 0; gap_chk = 0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_hdr_trdy", s_udp_hdr_trdy, 0);
        chk("rst_axis_trdy", s_axis_trdy, 0);
        chk("rst_m_hdr_tvalid", m_udp_hdr_tvalid, 0);
        chk("rst_m_axis_tvalid", m_axis_tvalid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_pkt_count", o_pkt_count, 0);
        @(posedge i_clk);
        #2 i_reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge i_clk);
            #1;
            done = (exp_h.size() == 0) && (exp_b.size() == 0);
            for (int p = 0; p < NP; p++) if (pq[p].size() != 0) done = 0;
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got %0d headers/%0d beats outstanding, expected 0",
                     name, exp_h.size(), exp_b.size());
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "drain timeout");
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic check_stats();
        for (int p = 0; p < NP; p++) begin
`ifdef UDP_TX_ARB_STATS_EN
            chk($sformatf("pkt_count%0d", p), o_pkt_count[16*p +: 16], 16'(m_cnt[p]));
`else
            chk($sformatf("pkt_count%0d", p), o_pkt_count[16*p +: 16], 0);
`endif
        end
    endtask

    initial begin
        i_reset = 1'b1;
        do_reset();

        // Single requester with fixed header.
        new_pkt(1, 16'h1234, 16'h5678, 16'h0000, 10);
        schedule();
        wait_drain("single");
        chk("single_grant", o_grant, 1);
        check_stats();

        // All ports contending from reset.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) rand_pkt(p, $urandom_range(1, 6));
        schedule();
        wait_drain("contend");
        check_stats();

        // Long packet under backpressure, with competitors queued.
        rand_pkt(1, 64);
        rand_pkt(0, 3);
        rand_pkt(3, 2);
        schedule();
        wait_drain("backpressure");

        // Pointer wrap: serve port 2, then ports 0 and 3 compete.
        do_reset();
        rand_pkt(2, 4);
        schedule();
        wait_drain("wrap_a");
        rand_pkt(0, 3);
        rand_pkt(3, 3);
        schedule();
        wait_drain("wrap_b");

        // Reset in the middle of port 2's packet.
        do_reset();
        rand_pkt(2, 10);
        stop_after = 5;
        schedule();
        for (int c = 0; c < 2000 && !hold; c++) @(negedge i_clk);
        if (!hold) begin
            errors++; checks++;
            $display("FAIL midrst_timeout: got %0d beats, expected 5", beats_seen);
        end
        do_reset();
        rand_pkt(2, 5);
        schedule();
        wait_drain("after_reset");

        // Randomized mixes.
        for (int ph = 0; ph < 6; ph++) begin
            for (int p = 0; p < NP; p++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) rand_pkt(p, $urandom_range(1, 8));
            end
            schedule();
            wait_drain("random");
            check_stats();
        end

        // Counter scenario: 3 packets on port 0, 1 on port 3.
        do_reset();
        for (int k = 0; k < 3; k++) rand_pkt(0, $urandom_range(1, 4));
        rand_pkt(3, 2);
        schedule();
        wait_drain("stats");
        check_stats();

        finish_run();
    end

endmodule

// File: doc/udp_tx_arb.md
# udp_tx_arb

Round-robin arbiter that shares one `udp_tx` engine between `NUM_PORTS` requesters.

- Each requester presents a UDP header (src/dst port, checksum) on a valid/ready channel, followed by an AXI-Stream payload.
- The block grants one requester at a time and forwards that requester's header, then its whole payload, to the `udp_tx` slave side.
- The grant is held until the payload beat carrying `tlast` has been accepted.
- Sits between the per-application UDP sources and `udp_tx`.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of requesters (2..8).
- `AXI_DATA_WIDTH`, 8, payload beat width.

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_reset`  in  1  synchronous, active-high reset.
- `s_udp_hdr_tvalid`  in  `NUM_PORTS`  per-port header valid.
- `s_udp_hdr_trdy`  out  `NUM_PORTS`  per-port header ready.
- `s_udp_src_port` / `s_udp_dst_port` / `s_udp_hdr_checksum`  in  `NUM_PORTS*16`  per-port header fields; port i occupies bits `[16i+15:16i]`.
- `s_axis_tdata`  in  `NUM_PORTS*AXI_DATA_WIDTH`  per-port payload.
- `s_axis_tvalid` / `s_axis_tlast`  in  `NUM_PORTS`  per-port payload valid / last.
- `s_axis_trdy`  out  `NUM_PORTS`  per-port payload ready.
- `m_udp_hdr_tvalid`  out  1  header valid toward `udp_tx`.
- `m_udp_hdr_trdy`  in  1  header ready from `udp_tx`.
- `m_udp_src_port` / `m_udp_dst_port` / `m_udp_hdr_checksum`  out  16  selected header fields.
- `m_axis_tdata`  out  `AXI_DATA_WIDTH`  selected payload.
- `m_axis_tvalid` / `m_axis_tlast`  out  1  selected payload valid / last.
- `m_axis_trdy`  in  1  payload ready from `udp_tx`.
- `o_grant`  out  `$clog2(NUM_PORTS)`  current or last granted port index.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_pkt_count`  out  `NUM_PORTS*16`  per-port packet counters (see Configuration).

## Operation
State machine: `IDLE` → `HDR` → `PAYLOAD` → `IDLE`.

- **IDLE**
  - If any `s_udp_hdr_tvalid` bit is set, pick the first set bit searching upward from `rr_ptr`, with wrap-around.
  - Register it into `grant`, go to `HDR`.
  - No `trdy` is asserted in IDLE.
- **HDR**
  - `m_udp_hdr_tvalid` = `s_udp_hdr_tvalid[grant]`; header fields are muxed from `grant`.
  - `s_udp_hdr_trdy[grant]` = `m_udp_hdr_trdy`.
  - On the handshake, go to `PAYLOAD`.
- **PAYLOAD**
  - `m_axis_*` are muxed from `grant`; `s_axis_trdy[grant]` = `m_axis_trdy`.
  - On `tvalid & trdy & tlast`: set `rr_ptr` ← `(grant+1) mod NUM_PORTS`, go to `IDLE`.
- Non-granted ports always see `s_udp_hdr_trdy = 0` and `s_axis_trdy = 0`.
- The header ready of the granted port is 0 outside `HDR`; its payload ready is 0 outside `PAYLOAD`.
- Output data/fields are don't-care when the matching valid is low; they are driven from the mux, not forced to 0.
- A requester dropping `s_udp_hdr_tvalid` while in `HDR` is legal. The grant is held and `m_udp_hdr_tvalid` follows the input.
- Fairness: a port just served is lowest priority at the next decision. Maximum wait is `NUM_PORTS-1` packets.
- Zero-length payloads are not supported. Every header must be followed by at least one beat with `tlast`.

## Timing
- Arbitration latency: a header valid sampled at edge k gives `m_udp_hdr_tvalid` high in the cycle after edge k. Minimum 1 cycle of latency from IDLE.
- Header and payload paths are combinational pass-through. There is zero added latency on the handshake and no buffering, so throughput is 1 beat/cycle within a packet.
- Inter-packet gap: at least 1 idle cycle (IDLE state) between a `tlast` handshake and the next `m_udp_hdr_tvalid`.
- Reset values:
  - state = IDLE, `grant` = 0, `rr_ptr` = 0, counters = 0.
  - All `trdy` outputs 0, `m_udp_hdr_tvalid` 0, `m_axis_tvalid` 0, `o_busy` 0.
- Reset mid-packet: the in-flight packet is abandoned with no `tlast` generated. The sink recovers via its own reset.
- Simultaneous requests: resolved purely by `rr_ptr`. With `rr_ptr` = 2 and requests on ports 0 and 3, port 3 wins.

## Configuration
- `UDP_TX_ARB_STATS_EN` defined:
  - Each port has a 16-bit packet counter, incremented on that port's `tlast` handshake.
  - Counters wrap from 0xFFFF to 0 and are cleared only by `i_reset`.
  - Driven on `o_pkt_count`.
- `UDP_TX_ARB_STATS_EN` undefined: counter logic is absent and `o_pkt_count` is tied to 0. The port list is unchanged.

## Structure
- `udp_pkg` holds `udp_arb_state_t` (`IDLE`/`HDR`/`PAYLOAD` enum) and the constant `UDP_HDR_FIELD_W` = 16.
- One sub-module, `rr_picker`:
  - Combinational round-robin first-set search.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: index and found flag.
- All state lives in `udp_tx_arb`.

## Test plan
1. **Single requester.** Port 1 sends header {src 0x1234, dst 0x5678, csum 0} plus a 10-byte payload → `m_*` carries identical fields and bytes, exactly 10 beats, `tlast` on beat 10, and `o_grant` = 1.
2. **All-port contention.** All 4 ports request continuously from reset → grant order 0,1,2,3,0,1,… over 8 packets, with no interleaving of payload bytes.
3. **Backpressure.** `m_axis_trdy` is toggled randomly at 50% during a 64-byte packet → all 64 bytes are delivered in order, and no non-granted `s_axis_trdy` is ever high.
4. **Pointer wrap.** `rr_ptr` = 3 after serving port 2, with requests on ports 0 and 3 → port 3 is granted first, then port 0.
5. **Mid-packet reset.** `i_reset` is pulsed for 1 cycle at beat 5 of port 2's packet → the next cycle shows all `trdy` = 0, `o_busy` = 0, `o_grant` = 0, and the following request from port 2 is served normally.
6. **Statistics (`UDP_TX_ARB_STATS_EN`).** 3 packets are sent from port 0 and 1 from port 3 → `o_pkt_count` reads port0 = 3, port3 = 1, others 0. Preloading via 65536 packets on one port wraps that counter to 0.
